// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns MEM-stage loads/stores into a req/gnt/rvalid bus handshake.
// Optional watchdog abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state;
    logic   mem_request;
    logic   req_complete;
    logic   timeout;
    logic   abort;

    assign mem_request  = mem_read | mem_write;
    assign req_complete = bus_gnt & (bus_we | bus_rvalid);
    assign abort        = timeout & (((state == REQ) & ~req_complete) |
                                     ((state == WAIT) & ~bus_rvalid));

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             err_flag;

    assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = err_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == IDLE && mem_request) begin
                cnt <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (abort) begin
                err_flag <= 1'b1;
            end
        end
    end
`else
    // The timeout length only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout        = 1'b0;
    assign bus_error      = 1'b0;
`endif

    // Stall asserts in the request cycle itself so the pipeline freezes before the bus is granted.
    assign mem_stall = ~reset & (((state == IDLE) & mem_request) |
                                 (state == REQ) | (state == WAIT));
    assign mem_done  = (state == DONE);
    assign bus_req   = (state == REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_request) begin
                        bus_we    <= mem_write;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_be    <= mem_be;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (abort) begin
                        mem_rdata <= '0;
                        state     <= DONE;
                    end else if (bus_gnt) begin
                        if (bus_we) begin
                            state <= DONE;
                        end else if (bus_rvalid) begin
                            mem_rdata <= bus_rdata;
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (abort) begin
                        mem_rdata <= '0;
                        state     <= DONE;
                    end else if (bus_rvalid) begin
                        mem_rdata <= bus_rdata;
                        state     <= DONE;
                    end
                end
                // The completing instruction is still on mem_read/mem_write here; it must not re-issue.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: vector table with a bus responder and a completion scoreboard.
// Covers the DMEM_TIMEOUT_EN build when that macro is defined, otherwise the wait-forever behaviour.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] JUNK   = 32'hEEEE_EEEE;
    localparam int          BUDGET = 300;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic        gap;
        int          exp_done;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          done;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_stall  (mem_stall),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .bus_error  (bus_error),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at posedge+1 with the DUT in IDLE; returns at posedge+1 after the DONE cycle.
    task automatic run_txn(input vec_t v, input string tag);
        int   req_cnt = 0;
        int   gcyc    = -1;
        int   stall   = 0;
        int   reqs    = 0;
        int   perr    = 0;
        int   done_at = -1;
        logic prev_req = 1'b0;
        exp_t e;
        mem_read  = v.rd;
        mem_write = v.wr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_be    = v.be;
        sb.push_back('{v.exp_rdata, v.exp_done});
        for (int cyc = 0; cyc < BUDGET && done_at < 0; cyc++) begin
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = JUNK;
            if (cyc == 0) begin
                bus_gnt    = 1'b1;
                bus_rvalid = 1'b1;
            end
            if (bus_req) begin
                if (req_cnt == v.gnt_dly) begin
                    bus_gnt = 1'b1;
                    gcyc    = cyc;
                end
                req_cnt++;
            end
            if (gcyc >= 0 && cyc == gcyc + v.rv_dly) begin
                bus_rvalid = 1'b1;
                bus_rdata  = v.rdata;
            end
            @(negedge clk);
            if (mem_stall) stall++;
            if (bus_req && !prev_req) reqs++;
            prev_req = bus_req;
            if (bus_req && ({bus_we, bus_addr, bus_wdata, bus_be} !== {v.wr, v.addr, v.wdata, v.be}))
                perr++;
            if (mem_done) begin
                done_at = cyc;
                if (sb.size() == 0) begin
                    check({tag, " spurious_done"}, 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check({tag, " done_cycle"}, 32'(cyc), 32'(e.done));
                    check({tag, " rdata"}, mem_rdata, e.rdata);
                end
                check({tag, " stall_in_done"}, {31'b0, mem_stall}, 32'd0);
                check({tag, " req_in_done"}, {31'b0, bus_req}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (done_at < 0) begin
            check({tag, " no_done_in_budget"}, 32'(BUDGET), 32'(v.exp_done));
            sb.delete();
        end
        check({tag, " stall_cycles"}, 32'(stall), 32'(v.exp_done));
        check({tag, " bus_requests"}, 32'(reqs), 32'd1);
        check({tag, " payload_errs"}, 32'(perr), 32'd0);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (v.gap) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            check({tag, " idle_stall"}, {31'b0, mem_stall}, 32'd0);
            check({tag, " idle_req"}, {31'b0, bus_req}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t tv;
        int   done_seen;

        //          rd    wr    addr         wdata         be     g  rv rdata         gap   done exp_rdata
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'hF,  0, 3, 32'hCAFE_F00D, 1'b0, 5, 32'hCAFE_F00D};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3,  0, 0, 32'hBAD0_BAD0, 1'b1, 2, 32'hCAFE_F00D};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'hF,  0, 0, 32'hA5A5_A5A5, 1'b0, 2, 32'hA5A5_A5A5};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0300, 32'hFFFF_0000, 4'hF,  2, 0, 32'hBAD1_BAD1, 1'b1, 4, 32'hA5A5_A5A5};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        4'hF,  3, 1, 32'h1357_9BDF, 1'b0, 6, 32'h1357_9BDF};
        tbl[5] = '{1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'h8,  1, 1, 32'hBAD2_BAD2, 1'b0, 3, 32'h1357_9BDF};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,        4'hF,  1, 0, 32'h2468_ACE0, 1'b1, 3, 32'h2468_ACE0};

        reset      = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = 32'h1111_1111;
        mem_wdata  = 32'h2222_2222;
        mem_be     = 4'hF;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = JUNK;
        repeat (2) @(negedge clk);
        check("rst mem_stall", {31'b0, mem_stall}, 32'd0);
        check("rst mem_done", {31'b0, mem_done}, 32'd0);
        check("rst bus_req", {31'b0, bus_req}, 32'd0);
        check("rst bus_we", {31'b0, bus_we}, 32'd0);
        check("rst bus_error", {31'b0, bus_error}, 32'd0);
        check("rst mem_rdata", mem_rdata, 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        check("rst bus_be", {28'b0, bus_be}, 32'd0);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        reset      = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Abandon a load while it is waiting for read data.
        mem_read  = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0500;
        mem_be    = 4'hF;
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        check("wait stall", {31'b0, mem_stall}, 32'd1);
        check("wait bus_req", {31'b0, bus_req}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async rst bus_req", {31'b0, bus_req}, 32'd0);
        check("async rst mem_stall", {31'b0, mem_stall}, 32'd0);
        done_seen = 0;
        @(posedge clk);
        #1;
        if (mem_done) done_seen++;
        @(negedge clk);
        if (mem_done) done_seen++;
        mem_read = 1'b0;
        reset    = 1'b0;
        check("rst abandon rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        if (mem_done) done_seen++;
        check("rst no done pulse", 32'(done_seen), 32'd0);
        tv = '{1'b1, 1'b0, 32'h0000_0504, 32'h0, 4'hF, 1, 2, 32'h0F0F_0F0F, 1'b1, 5, 32'h0F0F_0F0F};
        run_txn(tv, "post_rst");

`ifdef DMEM_TIMEOUT_EN
        tv = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 1000, 0, 32'h7777_7777, 1'b0, 9, 32'h0};
        run_txn(tv, "timeout");
        check("timeout bus_error", {31'b0, bus_error}, 32'd1);
`else
        tv = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 40, 0, 32'h7777_7777, 1'b0, 42, 32'h7777_7777};
        run_txn(tv, "long_wait");
        check("long_wait bus_error", {31'b0, bus_error}, 32'd0);
`endif
        tv = '{1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF, 0, 1, 32'h89AB_CDEF, 1'b1, 3, 32'h89AB_CDEF};
        run_txn(tv, "after_long");
`ifdef DMEM_TIMEOUT_EN
        check("sticky bus_error", {31'b0, bus_error}, 32'd1);
`else
        check("tied bus_error", {31'b0, bus_error}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum cycles a request may spend in REQ+WAIT before abort (legal range 2..1024).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 mem_read  input  1  SHALL flag a load in the MEM stage.
REQ-005 mem_write  input  1  SHALL flag a store in the MEM stage.
REQ-006 mem_addr  input  32  SHALL be the byte address of the access.
REQ-007 mem_wdata  input  32  SHALL be the store data.
REQ-008 mem_be  input  4  SHALL be the byte enables.
REQ-009 mem_stall  output  1  SHALL freeze IF/DE/EX/MEM and bubble WB while high.
REQ-010 mem_done  output  1  SHALL be a one-cycle pulse marking access completion.
REQ-011 mem_rdata  output  32  SHALL be the captured load data.
REQ-012 bus_error  output  1  SHALL be a sticky timeout flag.
REQ-013 bus_req, bus_we  output  1 each  SHALL be the request valid and write strobe.
REQ-014 bus_addr, bus_wdata  output  32 each, and bus_be  output  4  SHALL be the registered request payload.
REQ-015 bus_gnt  input  1  SHALL accept the request.
REQ-016 bus_rvalid  input  1, and bus_rdata  input  32  SHALL return read data.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-018 In IDLE, when mem_read or mem_write is high, the block SHALL capture addr/wdata/be/we into the payload registers and go to REQ next cycle.
REQ-019 In IDLE with a request present, mem_stall SHALL be high combinationally in that same cycle.
REQ-020 If mem_read and mem_write are both high, the access SHALL be treated as a write.
REQ-021 In REQ and WAIT, mem_stall SHALL be high.
REQ-022 In REQ, bus_req SHALL be high, and the payload SHALL stay stable until bus_gnt.
REQ-023 In REQ on bus_gnt: a write SHALL go to DONE; a read SHALL go to WAIT, or directly to DONE (capturing bus_rdata) if bus_rvalid is high in the same cycle.
REQ-024 In WAIT on bus_rvalid, the block SHALL capture bus_rdata into mem_rdata and go to DONE; bus_req SHALL be low in WAIT.
REQ-025 In DONE, the block SHALL drive mem_done=1 and mem_stall=0, ignore mem_read/mem_write (the completing instruction is still present), and return to IDLE.
REQ-026 Minimum latency SHALL be: request in IDLE at cycle N, grant at N+1, mem_done at N+2 (two stall cycles).
REQ-027 mem_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-028 bus_rvalid outside REQ/WAIT and bus_gnt outside REQ SHALL be ignored.

Reset
REQ-029 While reset is high, state SHALL be IDLE and mem_stall, mem_done, bus_req, bus_we, bus_error SHALL be 0; mem_rdata, bus_addr, bus_wdata, bus_be SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL drop bus_req asynchronously and abandon the access without a mem_done pulse.

Configuration
REQ-031 With DMEM_TIMEOUT_EN defined, a counter SHALL clear on IDLE->REQ and increment each REQ/WAIT cycle.
REQ-032 With DMEM_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1 without completion, the FSM SHALL go to DONE with mem_rdata=0, and bus_error SHALL set and stay set until reset.
REQ-033 Without DMEM_TIMEOUT_EN, the counter SHALL NOT exist, bus_error SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-034 Load at 0x100, gnt after 1 cycle, rvalid 3 cycles later with 0xCAFEF00D -> mem_stall high 5 cycles, one mem_done pulse, mem_rdata=0xCAFEF00D.
REQ-035 Store 0x12345678, be=4'b0011, gnt immediate -> bus_we=1, bus_be=0011 stable through grant, mem_done at cycle N+2, mem_rdata unchanged.
REQ-036 Load with gnt and rvalid in the same cycle carrying 0xA5A5A5A5 -> WAIT skipped, mem_done at N+2, mem_rdata=0xA5A5A5A5.
REQ-037 Back-to-back load then store (mem_read held through DONE) -> exactly one bus request per instruction, no duplicate request issued in DONE.
REQ-038 With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt never asserted -> abort after 8 REQ cycles, bus_error=1 sticky, mem_rdata=0.
REQ-039 Reset pulse while in WAIT -> bus_req/mem_stall 0 immediately; a subsequent load completes normally.
